// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single memory port between the instruction
// fetch unit (master 0) and the load/store unit (master 1). Only one access is
// outstanding at a time: IDLE -> REQ -> RESP -> IDLE.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When defined, ties go to the master
// opposite the previous winner. When undefined, ties use fixed priority and the LSU wins.
// Handshake rule for every channel: a transfer happens on the rising edge where
// valid && ready are both high. The source holds valid and its payload stable until
// that edge. Ready may change freely.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic                m0_req_wen,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_wmask,
    output logic                m0_resp_valid,
    input  logic                m0_resp_ready,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wmask,
    output logic                m1_resp_valid,
    input  logic                m1_resp_ready,
    output logic [DATA_W-1:0]   m_resp_rdata,
    output logic                m_resp_err,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wmask,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_resp_rdata,
    input  logic                s_resp_err,
    output logic                busy,
    output logic                grant,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                any_req;
    logic                winner;
    logic                sel_req_valid;
    logic                sel_resp_ready;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_wen;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_wmask;

    assign any_req   = m0_req_valid | m1_req_valid;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Response payload is shared; masters qualify it with their own resp_valid.
    assign m_resp_rdata = s_resp_rdata;
    assign m_resp_err   = s_resp_err;

    // Fields of whichever master currently holds the grant.
    assign sel_req_valid  = grant ? m1_req_valid  : m0_req_valid;
    assign sel_resp_ready = grant ? m1_resp_ready : m0_resp_ready;
    assign sel_addr       = grant ? m1_req_addr   : m0_req_addr;
    assign sel_wen        = grant ? m1_req_wen    : m0_req_wen;
    assign sel_wdata      = grant ? m1_req_wdata  : m0_req_wdata;
    assign sel_wmask      = grant ? m1_req_wmask  : m0_req_wmask;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie, pick the master that did not win the previous arbitration.
    always_comb begin
        winner = m1_req_valid;
        if (m0_req_valid && m1_req_valid) begin
            winner = ~last_grant;
        end
    end

    // Remember the winner of every arbitration. Reset value 1 hands the first tie to the IFU.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant <= winner;
        end
    end
`else
    // Fixed priority: the LSU wins whenever it is requesting.
    assign winner = m1_req_valid;
`endif

    // State and grant registers. Arbitration happens only in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                grant <= winner;
            end
        end
    end

    // Next state and channel routing. Handshake outputs are forced low while rst is high,
    // so an in-flight slave response is never taken during reset.
    always_comb begin
        state_next    = state;
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        s_req_valid   = 1'b0;
        s_req_addr    = '0;
        s_req_wen     = 1'b0;
        s_req_wdata   = '0;
        s_req_wmask   = '0;
        s_resp_ready  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state_next = REQ;
                    end
                end
                REQ: begin
                    s_req_valid = sel_req_valid;
                    s_req_addr  = sel_addr;
                    s_req_wen   = sel_wen;
                    s_req_wdata = sel_wdata;
                    s_req_wmask = sel_wmask;
                    if (grant) begin
                        m1_req_ready = s_req_ready;
                    end else begin
                        m0_req_ready = s_req_ready;
                    end
                    if (sel_req_valid && s_req_ready) begin
                        state_next = RESP;
                    end
                end
                RESP: begin
                    s_resp_ready = sel_resp_ready;
                    if (grant) begin
                        m1_resp_valid = s_resp_valid;
                    end else begin
                        m0_resp_valid = s_resp_valid;
                    end
                    if (s_resp_valid && sel_resp_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Build with +define+ARB_ROUND_ROBIN_EN to match a
// round-robin DUT build. Stimulus and the bench slave are driven on the falling edge;
// the monitor samples 2 time units later and checks against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MW      = DATA_W / 8;
    localparam int PH_FREE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_RESP = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MW-1:0]     wmask;
    } req_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              m0_req_valid, m0_req_ready, m0_req_wen, m0_resp_valid, m0_resp_ready;
    logic [ADDR_W-1:0] m0_req_addr;
    logic [DATA_W-1:0] m0_req_wdata;
    logic [MW-1:0]     m0_req_wmask;
    logic              m1_req_valid, m1_req_ready, m1_req_wen, m1_resp_valid, m1_resp_ready;
    logic [ADDR_W-1:0] m1_req_addr;
    logic [DATA_W-1:0] m1_req_wdata;
    logic [MW-1:0]     m1_req_wmask;
    logic [DATA_W-1:0] m_resp_rdata;
    logic              m_resp_err;
    logic              s_req_valid, s_req_ready, s_req_wen, s_resp_valid, s_resp_ready, s_resp_err;
    logic [ADDR_W-1:0] s_req_addr;
    logic [DATA_W-1:0] s_req_wdata, s_resp_rdata;
    logic [MW-1:0]     s_req_wmask;
    logic              busy, grant;
    logic [1:0]        state_dbg;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
        .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_rdata(s_resp_rdata),
        .s_resp_err(s_resp_err),
        .busy(busy), .grant(grant), .state_dbg(state_dbg)
    );

    // Bench slave behaviour: the response is a fixed function of the request.
    function automatic logic [DATA_W:0] slave_resp(req_t r);
        logic [DATA_W-1:0] d;
        logic              e;
        e = (r.addr[7:4] == 4'hE);
        if (r.wen) d = '0;
        else if (r.addr == 32'h8000_0000) d = 32'h0000_0013;
        else d = (r.addr * 32'd3) ^ 32'hA5A5_1234;
        return {e, d};
    endfunction

    // scoreboard queues
    req_t              req_q0[$], req_q1[$];
    logic [DATA_W:0]   exp_q0[$], exp_q1[$];
    logic              seq_q[$];

    // stimulus-side state
    bit   m_act[2];
    int   m_left[2], m_gap[2], rr_pct[2], acc_seen[2];
    req_t m_cur[2], fx_req[2];
    bit   fx_en[2];
    int   gap_max, sr_pct, dly_lo, dly_hi, sacc_seen, rsp_seen, sl_dly, tmo_cnt;
    bit   sl_pend, fin;
    req_t sl_req;

    // monitor-side state
    int   acc_cnt[2];
    int   rsp_cnt, phase, n_chk, n_fail, tmo_seen;
    logic grant_exp, last_exp;
    req_t cap_req;
    bit   fin_done;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // driver: one clock of master agents and the slave
    task automatic cycle();
        logic [DATA_W:0] rsp;
        @(negedge clk);
        if (acc_cnt[0] + acc_cnt[1] != sacc_seen) begin
            sacc_seen = acc_cnt[0] + acc_cnt[1];
            sl_pend   = 1'b1;
            sl_req    = cap_req;
            sl_dly    = $urandom_range(dly_lo, dly_hi);
        end else if (rsp_cnt != rsp_seen) begin
            rsp_seen = rsp_cnt;
            sl_pend  = 1'b0;
        end
        s_resp_valid = sl_pend && (sl_dly == 0);
        if (s_resp_valid) begin
            rsp = slave_resp(sl_req);
            {s_resp_err, s_resp_rdata} = rsp;
        end else begin
            s_resp_rdata = $urandom;
            s_resp_err   = 1'($urandom_range(0, 1));
        end
        if (sl_pend && sl_dly > 0) sl_dly--;
        s_req_ready = ($urandom_range(0, 99) < sr_pct);
        for (int m = 0; m < 2; m++) begin
            if (acc_cnt[m] != acc_seen[m]) begin
                acc_seen[m] = acc_cnt[m];
                m_act[m]    = 1'b0;
                m_gap[m]    = $urandom_range(0, gap_max);
            end
            if (!m_act[m] && m_left[m] > 0) begin
                if (m_gap[m] > 0) begin
                    m_gap[m]--;
                end else begin
                    if (fx_en[m]) begin
                        m_cur[m] = fx_req[m];
                    end else begin
                        m_cur[m].addr  = {$urandom} & 32'hFFFF_FFFC;
                        m_cur[m].wen   = 1'($urandom_range(0, 1));
                        m_cur[m].wdata = $urandom;
                        m_cur[m].wmask = 4'($urandom_range(0, 15));
                    end
                    m_act[m] = 1'b1;
                    m_left[m]--;
                    if (m == 0) begin
                        req_q0.push_back(m_cur[m]);
                        exp_q0.push_back(slave_resp(m_cur[m]));
                    end else begin
                        req_q1.push_back(m_cur[m]);
                        exp_q1.push_back(slave_resp(m_cur[m]));
                    end
                end
            end
        end
        m0_req_valid  = m_act[0];
        {m0_req_addr, m0_req_wen, m0_req_wdata, m0_req_wmask} = m_cur[0];
        m0_resp_ready = ($urandom_range(0, 99) < rr_pct[0]);
        m1_req_valid  = m_act[1];
        {m1_req_addr, m1_req_wen, m1_req_wdata, m1_req_wmask} = m_cur[1];
        m1_resp_ready = ($urandom_range(0, 99) < rr_pct[1]);
    endtask

    // reset for n cycles; a stray IFU request is presented and must be ignored
    task automatic do_reset(input int n);
        @(negedge clk);
        rst           = 1'b1;
        m0_req_valid  = 1'b1;
        m0_req_addr   = $urandom;
        m1_req_valid  = 1'b0;
        s_req_ready   = 1'b1;
        m0_resp_ready = 1'b1;
        m1_resp_ready = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        req_q0.delete(); req_q1.delete(); exp_q0.delete(); exp_q1.delete();
        m_act     = '{1'b0, 1'b0};
        m_left    = '{0, 0};
        m_gap     = '{0, 0};
        fx_en     = '{1'b0, 1'b0};
        sl_pend   = 1'b0;
        acc_seen  = acc_cnt;
        sacc_seen = acc_cnt[0] + acc_cnt[1];
        rsp_seen  = rsp_cnt;
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        s_resp_valid = 1'b0;
        s_req_ready  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((m_left[0] > 0 || m_left[1] > 0 || m_act[0] || m_act[1] || phase != PH_FREE)
               && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) tmo_cnt++;
        cycle();
    endtask

    task automatic wait_phase(input int p, input int budget);
        int k;
        k = 0;
        while (phase != p && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) tmo_cnt++;
    endtask

    // monitor: transaction-level model of the arbiter, checked every cycle
    always @(negedge clk) begin : monitor
        logic            win, mv, rrdy;
        req_t            hold;
        logic [DATA_W:0] e;
        #2;
        if (tmo_cnt != tmo_seen) begin
            chk("wait_budget", 128'(tmo_cnt), 128'(tmo_seen));
            tmo_seen = tmo_cnt;
        end
        if (fin && !fin_done) begin
            chk("exp_q_drained", 128'(exp_q0.size() + exp_q1.size()), 128'd0);
            fin_done = 1'b1;
        end
        if (rst) begin
            chk("rst_handshakes", 128'({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
                                        s_req_valid, s_resp_ready}), 128'd0);
            chk("rst_s_req_fields", 128'({s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}), 128'd0);
            phase     = PH_FREE;
            grant_exp = 1'b0;
            last_exp  = 1'b1;
        end else begin
            chk("busy", 128'(busy), 128'(phase != PH_FREE));
            chk("grant", 128'(grant), 128'(grant_exp));
            chk("resp_passthru", 128'({m_resp_err, m_resp_rdata}), 128'({s_resp_err, s_resp_rdata}));
            case (phase)
                PH_FREE: begin
                    chk("idle_handshakes", 128'({m0_req_ready, m1_req_ready, m0_resp_valid,
                                                 m1_resp_valid, s_req_valid, s_resp_ready}), 128'd0);
                    chk("idle_s_req_fields", 128'({s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}), 128'd0);
                    if (m0_req_valid || m1_req_valid) begin
                        if (m0_req_valid && m1_req_valid) win = RR ? ~last_exp : 1'b1;
                        else win = m1_req_valid;
                        if (seq_q.size() > 0) chk("grant_order", 128'(win), 128'(seq_q.pop_front()));
                        grant_exp = win;
                        last_exp  = win;
                        phase     = PH_REQ;
                    end
                end
                PH_REQ: begin
                    mv = grant_exp ? m1_req_valid : m0_req_valid;
                    chk("req_q_has_entry", 128'(grant_exp ? req_q1.size() > 0 : req_q0.size() > 0), 128'd1);
                    hold = '0;
                    if (grant_exp && req_q1.size() > 0) hold = req_q1[0];
                    if (!grant_exp && req_q0.size() > 0) hold = req_q0[0];
                    chk("s_req_valid", 128'(s_req_valid), 128'(mv));
                    chk("s_req_fields", 128'({s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}), 128'(hold));
                    chk("req_ready", 128'({m0_req_ready, m1_req_ready}),
                        128'(grant_exp ? {1'b0, s_req_ready} : {s_req_ready, 1'b0}));
                    chk("req_phase_resp", 128'({m0_resp_valid, m1_resp_valid, s_resp_ready}), 128'd0);
                    if (mv && s_req_ready) begin
                        cap_req = hold;
                        if (grant_exp && req_q1.size() > 0) void'(req_q1.pop_front());
                        if (!grant_exp && req_q0.size() > 0) void'(req_q0.pop_front());
                        acc_cnt[grant_exp]++;
                        phase = PH_RESP;
                    end
                end
                default: begin
                    rrdy = grant_exp ? m1_resp_ready : m0_resp_ready;
                    chk("resp_valid", 128'({m0_resp_valid, m1_resp_valid}),
                        128'(grant_exp ? {1'b0, s_resp_valid} : {s_resp_valid, 1'b0}));
                    chk("s_resp_ready", 128'(s_resp_ready), 128'(rrdy));
                    chk("resp_phase_req", 128'({m0_req_ready, m1_req_ready, s_req_valid}), 128'd0);
                    chk("resp_s_req_fields", 128'({s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}), 128'd0);
                    if (s_resp_valid && rrdy) begin
                        chk("exp_q_has_entry", 128'(grant_exp ? exp_q1.size() > 0 : exp_q0.size() > 0), 128'd1);
                        e = '0;
                        if (grant_exp && exp_q1.size() > 0) e = exp_q1.pop_front();
                        if (!grant_exp && exp_q0.size() > 0) e = exp_q0.pop_front();
                        chk("resp_data_err", 128'({m_resp_err, m_resp_rdata}), 128'(e));
                        rsp_cnt++;
                        phase = PH_FREE;
                    end
                end
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // stimulus sequence
    initial begin
        m0_req_valid = 0; m0_req_addr = '0; m0_req_wen = 0; m0_req_wdata = '0; m0_req_wmask = '0;
        m1_req_valid = 0; m1_req_addr = '0; m1_req_wen = 0; m1_req_wdata = '0; m1_req_wmask = '0;
        m0_resp_ready = 0; m1_resp_ready = 0;
        s_req_ready = 0; s_resp_valid = 0; s_resp_rdata = '0; s_resp_err = 0;
        gap_max = 0; sr_pct = 100; dly_lo = 0; dly_hi = 0; rr_pct = '{100, 100};
        tmo_cnt = 0; fin = 0;
        do_reset(3);

        // IFU read alone, slave always ready and answering at once
        fx_en[0] = 1'b1; fx_req[0] = '{addr: 32'h8000_0000, wen: 1'b0, wdata: '0, wmask: '0};
        m_left[0] = 1;
        wait_done(50);

        // tie: both masters request continuously, 4 transactions each
        do_reset(1);
        for (int i = 0; i < 8; i++)
            seq_q.push_back(RR ? 1'(i % 2) : 1'(i < 4));
        m_left = '{4, 4};
        wait_done(200);

        // backpressure on the slave request, then on the LSU response
        do_reset(1);
        fx_en = '{1'b1, 1'b1};
        fx_req[0] = '{addr: 32'h8000_0200, wen: 1'b0, wdata: '0, wmask: '0};
        fx_req[1] = '{addr: 32'h8000_0100, wen: 1'b1, wdata: 32'hDEAD_BEEF, wmask: 4'hF};
        m_left = '{1, 1};
        m_gap  = '{2, 0};
        sr_pct = 0; rr_pct = '{100, 0};
        wait_phase(PH_REQ, 20);
        repeat (3) cycle();
        sr_pct = 100;
        wait_phase(PH_RESP, 20);
        repeat (2) cycle();
        rr_pct[1] = 100;
        wait_done(100);

        // reset while in RESP, then a normal IFU read
        do_reset(1);
        fx_en[1] = 1'b1; fx_req[1] = '{addr: 32'h8000_0040, wen: 1'b0, wdata: '0, wmask: '0};
        m_left[1] = 1; dly_lo = 6; dly_hi = 6;
        wait_phase(PH_RESP, 20);
        do_reset(1);
        dly_lo = 0; dly_hi = 2;
        fx_en[0] = 1'b1; fx_req[0] = '{addr: 32'h8000_0000, wen: 1'b0, wdata: '0, wmask: '0};
        m_left[0] = 1;
        wait_done(50);

        // slave error on an LSU read
        fx_en[1] = 1'b1; fx_req[1] = '{addr: 32'h8000_00E0, wen: 1'b0, wdata: '0, wmask: '0};
        m_left[1] = 1;
        wait_done(50);

        // randomized traffic
        fx_en = '{1'b0, 1'b0};
        gap_max = 3; sr_pct = 70; rr_pct = '{70, 70}; dly_lo = 0; dly_hi = 3;
        m_left = '{40, 40};
        wait_done(4000);

        fin = 1'b1;
        repeat (3) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master, one-slave arbiter that shares the core's single memory port between the instruction fetch unit (master 0, IFU) and the load/store unit (master 1, LSU). It sits between the fetch stage, which feeds `fetch_id_pipe`, and the memory-side bus. It serialises transactions with one outstanding access at a time. It uses valid/ready handshakes on every channel.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; write mask width is `DATA_W/8`.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `m0_req_valid` / `m1_req_valid`  in  1  master request valid.
- `m0_req_ready` / `m1_req_ready`  out  1  request accepted.
- `m0_req_addr` / `m1_req_addr`  in  ADDR_W  request address.
- `m0_req_wen` / `m1_req_wen`  in  1  1 = write, 0 = read.
- `m0_req_wdata` / `m1_req_wdata`  in  DATA_W  write data.
- `m0_req_wmask` / `m1_req_wmask`  in  DATA_W/8  byte enables.
- `m0_resp_valid` / `m1_resp_valid`  out  1  response valid.
- `m0_resp_ready` / `m1_resp_ready`  in  1  master takes response.
- `m_resp_rdata`  out  DATA_W  read data, shared by both masters.
- `m_resp_err`  out  1  error flag, shared by both masters.
- `s_req_valid`  out  1  request to slave.
- `s_req_ready`  in  1  slave accepts request.
- `s_req_addr`  out  ADDR_W  forwarded request field.
- `s_req_wen`  out  1  forwarded request field.
- `s_req_wdata`  out  DATA_W  forwarded request field.
- `s_req_wmask`  out  DATA_W/8  forwarded request field.
- `s_resp_valid`  in  1  slave response valid.
- `s_resp_ready`  out  1  arbiter takes response.
- `s_resp_rdata`  in  DATA_W  slave read data.
- `s_resp_err`  in  1  slave error flag.
- `busy`  out  1  high in any state other than IDLE.
- `grant`  out  1  registered winner index (0 = IFU, 1 = LSU).

## Operation
- States: IDLE, REQ, RESP. The state and the `grant` register are the only state, plus `last_grant` when round-robin is configured.
- IDLE:
  - If any `mX_req_valid` is high, latch the winner into `grant` and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `s_req_*` equals the granted master's request fields.
  - `s_req_valid` equals the granted master's `req_valid`.
  - The granted master's `req_ready` equals `s_req_ready`.
  - On `s_req_valid && s_req_ready`, go to RESP.
- RESP:
  - The granted master's `resp_valid` equals `s_resp_valid`.
  - `s_resp_ready` equals the granted master's `resp_ready`.
  - On the response handshake, go to IDLE.
- The non-granted master always sees `req_ready` = 0 and `resp_valid` = 0.
- `s_req_valid` and `s_req_*` are 0 outside REQ. `s_resp_ready` is 0 outside RESP.
- `m_resp_rdata` and `m_resp_err` pass `s_resp_*` through unconditionally. Qualify them with `mX_resp_valid`.
- Masters hold `req_valid` and request fields stable until accepted. If a master withdraws its request in REQ, the arbiter stays in REQ with `s_req_valid` = 0.
- Default arbitration is fixed priority: when both masters request in IDLE, the LSU wins.

## Timing
- Arbitration costs one cycle. A request seen in IDLE at edge N reaches the slave in cycle N+1.
- Minimum transaction is 3 cycles: IDLE → REQ (slave ready at once) → RESP (response in the same cycle) → IDLE.
- No back-to-back streaming: after a response handshake there is always one IDLE cycle.
- A new request can be accepted only after the previous response handshake completes.
- Reset values: state = IDLE, `grant` = 0, `last_grant` = 1, `busy` = 0.
- All ready/valid outputs and all `s_req_*` fields are 0 during and after reset.
- Reset mid-transaction: the arbiter returns to IDLE on the next edge. Any in-flight slave response is not accepted; the slave is reset on the same `rst`.
- Requests present in the same cycle that `rst` is asserted are ignored.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On a tie in IDLE, grant the master opposite to `last_grant`.
  - `last_grant` updates to the winner on every IDLE → REQ transition.
  - Because `last_grant` resets to 1, the first tie after reset goes to the IFU.
- Undefined: fixed priority, LSU always wins ties. `last_grant` is not implemented.

## Test plan
- IFU read alone:
  - Stimulus: `m0_req_valid` = 1, addr = 0x8000_0000; the slave returns 0x0000_0013 one cycle after acceptance.
  - Response: `s_req_valid` rises in cycle 1; `m0_resp_valid` = 1 with rdata 0x13 in cycle 2; `busy` returns to 0 after the handshake.
- Tie, fixed priority (macro undefined):
  - Stimulus: both masters request in the same cycle, twice in a row.
  - Response: the LSU is granted both times; the IFU is granted after the LSU's second response, with `grant` = 0.
- Tie, round-robin (`ARB_ROUND_ROBIN_EN`):
  - Stimulus: both masters continuously request 4 transactions each.
  - Response: grants alternate IFU, LSU, IFU, LSU… starting with the IFU.
- Backpressure:
  - Stimulus: `s_req_ready` is held low for 3 cycles, then `m1_resp_ready` is held low for 2 cycles.
  - Response: the LSU write (addr 0x8000_0100, wdata 0xDEADBEEF, wmask 0xF) stays stable on `s_req_*`; the state stays REQ, then RESP; `m0_req_ready` stays 0 throughout.
- Reset mid-RESP:
  - Stimulus: assert `rst` for one cycle while in RESP.
  - Response: next cycle state = IDLE with all valid/ready outputs 0; a subsequent IFU request completes normally.
- Slave error:
  - Stimulus: `s_resp_err` = 1 on an LSU read.
  - Response: `m_resp_err` = 1 in the same cycle as `m1_resp_valid`; `m0_resp_valid` stays 0.
